// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared widths and packet types for the branch resolve queue
package bp_pkg;

    localparam int BP_ADDR_W      = 22;
    localparam int BP_GHR_W       = 8;
    localparam int BP_NUM_THREADS = 4;
    localparam int BP_DEPTH       = 4;
    localparam int THREAD_W       = 2;

    // One in-flight prediction: what was predicted, where it came from, where to recover to
    typedef struct packed {
        logic                  taken;
        logic [BP_GHR_W-1:0]   index;
        logic [BP_ADDR_W-1:0]  alt_pc;
    } bp_entry_t;

    // Feedback packet for the gshare predictor
    typedef struct packed {
        logic [THREAD_W-1:0]   thread;
        logic [BP_GHR_W-1:0]   index;
        logic                  taken;
        logic                  mispredict;
    } bp_update_t;

endpackage

// File: rtl/branch_inflight_fifo.sv
// rtl/branch_inflight_fifo.sv - one thread's in-flight branch FIFO with wrong-path flush
module branch_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH
) (
    input  logic      i_Clk,
    input  logic      i_Reset_n,
    input  logic      i_push,
    input  bp_entry_t i_push_entry,
    input  logic      i_pop,
    input  logic      i_flush,
    output bp_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W-1:0] flush_ptr;
    bp_entry_t        mem [DEPTH];

    assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
    // A flush collapses the queue onto the read pointer as it will be after this edge
    assign flush_ptr  = i_pop ? rd_ptr_nxt : rd_ptr;

    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign o_head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush overrides any same-cycle push, which is wrong-path
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (i_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (i_flush) begin
                wr_ptr <= flush_ptr;
            end else if (i_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    // Entry storage; contents are only meaningful between the pointers so no reset
    always_ff @(posedge i_Clk) begin
        if (i_push && !i_flush) begin
            mem[wr_ptr[AW-1:0]] <= i_push_entry;
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - per-thread branch tracking, resolve compare, predictor feedback and redirect
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter int ADDRESS_WIDTH = BP_ADDR_W,
    parameter int GHR_SIZE      = BP_GHR_W,
    parameter int NUM_THREADS   = BP_NUM_THREADS,
    parameter int DEPTH         = BP_DEPTH
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_fetch_valid,
    input  logic [THREAD_W-1:0]      i_fetch_thread,
    input  logic                     i_fetch_taken,
    input  logic [GHR_SIZE-1:0]      i_fetch_index,
    input  logic [ADDRESS_WIDTH-1:0] i_fetch_alt_pc,
    output logic                     o_fetch_stall,
    input  logic                     i_res_valid,
    input  logic [THREAD_W-1:0]      i_res_thread,
    input  logic                     i_res_taken,
    output logic                     o_upd_valid,
    output logic [THREAD_W-1:0]      o_upd_thread,
    output logic [GHR_SIZE-1:0]      o_upd_index,
    output logic                     o_upd_taken,
    output logic                     o_upd_mispredict,
    output logic                     o_redirect_valid,
    output logic [THREAD_W-1:0]      o_redirect_thread,
    output logic [ADDRESS_WIDTH-1:0] o_redirect_pc,
    output logic [NUM_THREADS-1:0]   o_empty,
    output logic                     o_error
);

    logic [NUM_THREADS-1:0] full_flags;
    logic [NUM_THREADS-1:0] empty_flags;
    bp_entry_t              heads [NUM_THREADS];
    bp_entry_t              push_entry;
    bp_entry_t              res_head;
    logic                   res_fire;
    logic                   res_mispredict;
    bp_update_t             upd_q;

    assign push_entry     = '{taken: i_fetch_taken, index: i_fetch_index, alt_pc: i_fetch_alt_pc};
    assign res_head       = heads[i_res_thread];
    assign res_fire       = i_res_valid && !empty_flags[i_res_thread];
    assign res_mispredict = res_head.taken ^ i_res_taken;

    assign o_fetch_stall  = full_flags[i_fetch_thread];
    assign o_empty        = empty_flags;

    genvar t;
    generate
        for (t = 0; t < NUM_THREADS; t++) begin : g_thread
            logic push_t;
            logic pop_t;

            assign push_t = i_fetch_valid && (i_fetch_thread == THREAD_W'(t)) && !full_flags[t];
            assign pop_t  = res_fire && (i_res_thread == THREAD_W'(t));

            branch_inflight_fifo #(
                .DEPTH(DEPTH)
            ) u_fifo (
                .i_Clk       (i_Clk),
                .i_Reset_n   (i_Reset_n),
                .i_push      (push_t),
                .i_push_entry(push_entry),
                .i_pop       (pop_t),
                .i_flush     (pop_t && res_mispredict),
                .o_head      (heads[t]),
                .o_full      (full_flags[t]),
                .o_empty     (empty_flags[t])
            );
        end
    endgenerate

    // Predictor update packet; payload holds its last value between strobes
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_upd_valid <= 1'b0;
            upd_q       <= '0;
        end else begin
            o_upd_valid <= res_fire;
            if (res_fire) begin
                upd_q <= '{thread: i_res_thread, index: res_head.index,
                           taken: i_res_taken, mispredict: res_mispredict};
            end
        end
    end

    assign o_upd_thread     = upd_q.thread;
    assign o_upd_index      = upd_q.index;
    assign o_upd_taken      = upd_q.taken;
    assign o_upd_mispredict = upd_q.mispredict;

    // Fetch redirect to the path not taken at prediction time
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_redirect_valid  <= 1'b0;
            o_redirect_thread <= '0;
            o_redirect_pc     <= '0;
        end else begin
            o_redirect_valid <= res_fire && res_mispredict;
            if (res_fire && res_mispredict) begin
                o_redirect_thread <= i_res_thread;
                o_redirect_pc     <= res_head.alt_pc;
            end
        end
    end

    // Sticky flag for a resolve with nothing in flight on that thread
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_error <= 1'b0;
        end else if (i_res_valid && empty_flags[i_res_thread]) begin
            o_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - scoreboard bench for branch_resolve_queue
module tb_branch_resolve_queue;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [1:0]  fetch_thread;
    logic        fetch_taken;
    logic [7:0]  fetch_index;
    logic [21:0] fetch_alt_pc;
    logic        fetch_stall;
    logic        res_valid;
    logic [1:0]  res_thread;
    logic        res_taken;
    logic        upd_valid;
    logic [1:0]  upd_thread;
    logic [7:0]  upd_index;
    logic        upd_taken;
    logic        upd_mispredict;
    logic        redirect_valid;
    logic [1:0]  redirect_thread;
    logic [21:0] redirect_pc;
    logic [3:0]  empty;
    logic        error;

    typedef struct {
        logic [1:0]  thread;
        logic [7:0]  index;
        logic        taken;
        logic        mispredict;
        logic        redir;
        logic [21:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    branch_resolve_queue dut (
        .i_Clk            (clk),
        .i_Reset_n        (rst_n),
        .i_fetch_valid    (fetch_valid),
        .i_fetch_thread   (fetch_thread),
        .i_fetch_taken    (fetch_taken),
        .i_fetch_index    (fetch_index),
        .i_fetch_alt_pc   (fetch_alt_pc),
        .o_fetch_stall    (fetch_stall),
        .i_res_valid      (res_valid),
        .i_res_thread     (res_thread),
        .i_res_taken      (res_taken),
        .o_upd_valid      (upd_valid),
        .o_upd_thread     (upd_thread),
        .o_upd_index      (upd_index),
        .o_upd_taken      (upd_taken),
        .o_upd_mispredict (upd_mispredict),
        .o_redirect_valid (redirect_valid),
        .o_redirect_thread(redirect_thread),
        .o_redirect_pc    (redirect_pc),
        .o_empty          (empty),
        .o_error          (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic expect_upd(input logic [1:0] th, input logic [7:0] idx, input logic tk,
                              input logic misp, input logic [21:0] pc);
        exp_t e;
        e.thread = th; e.index = idx; e.taken = tk; e.mispredict = misp;
        e.redir = misp; e.pc = pc;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus, driven just after the rising edge
    task automatic step(input logic fv, input logic [1:0] ft, input logic ftk, input logic [7:0] fidx,
                        input logic [21:0] fpc, input logic rv, input logic [1:0] rt, input logic rtk);
        fetch_valid = fv; fetch_thread = ft; fetch_taken = ftk; fetch_index = fidx; fetch_alt_pc = fpc;
        res_valid = rv; res_thread = rt; res_taken = rtk;
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        res_valid   = 1'b0;
    endtask

    task automatic push(input logic [1:0] th, input logic tk, input logic [7:0] idx, input logic [21:0] pc);
        step(1'b1, th, tk, idx, pc, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic resolve(input logic [1:0] th, input logic tk);
        step(1'b0, 2'd0, 1'b0, 8'h00, 22'h0, 1'b1, th, tk);
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 1'b0, 8'h00, 22'h0, 1'b0, 2'd0, 1'b0);
    endtask

    // Monitor: every update strobe must match the oldest expected resolve
    always @(negedge clk) begin
        if (rst_n) begin
            if (upd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_upd: got index %0h expected no update", upd_index);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("upd_thread", 32'(upd_thread), 32'(e.thread));
                    check("upd_index", 32'(upd_index), 32'(e.index));
                    check("upd_taken", 32'(upd_taken), 32'(e.taken));
                    check("upd_mispredict", 32'(upd_mispredict), 32'(e.mispredict));
                    check("redirect_valid", 32'(redirect_valid), 32'(e.redir));
                    if (e.redir) begin
                        check("redirect_thread", 32'(redirect_thread), 32'(e.thread));
                        check("redirect_pc", 32'(redirect_pc), 32'(e.pc));
                    end
                end
            end else if (redirect_valid) begin
                check("redirect_without_upd", 32'(redirect_valid), 32'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        fetch_valid = 1'b0; fetch_thread = 2'd0; fetch_taken = 1'b0; fetch_index = 8'h00; fetch_alt_pc = 22'h0;
        res_valid = 1'b0; res_thread = 2'd0; res_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_empty", 32'(empty), 32'hF);
        check("reset_upd_valid", 32'(upd_valid), 32'd0);
        check("reset_redirect_valid", 32'(redirect_valid), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_stall", 32'(fetch_stall), 32'd0);
        check("reset_redirect_pc", 32'(redirect_pc), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Correct prediction on thread 0
        push(2'd0, 1'b1, 8'h3C, 22'h000104);
        check("t0_not_empty", 32'(empty[0]), 32'd0);
        expect_upd(2'd0, 8'h3C, 1'b1, 1'b0, 22'h0);
        resolve(2'd0, 1'b1);
        check("t0_empty_after", 32'(empty[0]), 32'd1);
        idle();

        // Mispredict on thread 2 flushes the two younger entries
        push(2'd2, 1'b0, 8'h21, 22'h000200);
        push(2'd2, 1'b1, 8'h22, 22'h000300);
        push(2'd2, 1'b0, 8'h23, 22'h000400);
        expect_upd(2'd2, 8'h21, 1'b1, 1'b1, 22'h000200);
        resolve(2'd2, 1'b1);
        check("t2_flushed_empty", 32'(empty[2]), 32'd1);
        idle();
        push(2'd2, 1'b1, 8'h24, 22'h000500);
        expect_upd(2'd2, 8'h24, 1'b1, 1'b0, 22'h0);
        resolve(2'd2, 1'b1);
        idle();

        // Fill thread 1, check stall, drop extra pushes, drain in order
        for (int i = 0; i < 4; i++) begin
            push(2'd1, 1'b0, 8'h40 + 8'(i), 22'h001000 + 22'(i));
        end
        fetch_thread = 2'd1;
        #1;
        check("t1_full_stall", 32'(fetch_stall), 32'd1);
        fetch_thread = 2'd0;
        #1;
        check("t0_no_stall", 32'(fetch_stall), 32'd0);
        push(2'd1, 1'b0, 8'h44, 22'h001004);
        expect_upd(2'd1, 8'h40, 1'b0, 1'b0, 22'h0);
        step(1'b1, 2'd1, 1'b0, 8'h45, 22'h001005, 1'b1, 2'd1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            check("t1_not_empty_mid", 32'(empty[1]), 32'd0);
            expect_upd(2'd1, 8'h40 + 8'(i), 1'b0, 1'b0, 22'h0);
            resolve(2'd1, 1'b0);
        end
        check("t1_empty_after_drain", 32'(empty[1]), 32'd1);
        idle();

        // Thread 3: ten entries in batches of three, crossing the pointer wrap
        for (int i = 0; i < 10; i++) begin
            fetch_thread = 2'd3;
            #1;
            check("t3_no_spurious_full", 32'(fetch_stall), 32'd0);
            push(2'd3, 1'(i), 8'h80 + 8'(i), 22'h002000 + 22'(i));
            if ((i % 3) == 2 || i == 9) begin
                for (int j = (i / 3) * 3; j <= i; j++) begin
                    expect_upd(2'd3, 8'h80 + 8'(j), 1'(j), 1'b0, 22'h0);
                    resolve(2'd3, 1'(j));
                end
                check("t3_empty_batch", 32'(empty[3]), 32'd1);
            end
        end
        idle();

        // Same-cycle push and mispredicting resolve on thread 0
        push(2'd0, 1'b0, 8'h50, 22'h000600);
        expect_upd(2'd0, 8'h50, 1'b1, 1'b1, 22'h000600);
        step(1'b1, 2'd0, 1'b1, 8'h11, 22'h000700, 1'b1, 2'd0, 1'b1);
        check("t0_flush_push_dropped", 32'(empty[0]), 32'd1);
        check("error_still_clear", 32'(error), 32'd0);
        idle();

        // Resolve on an empty queue
        resolve(2'd1, 1'b1);
        check("empty_res_upd", 32'(upd_valid), 32'd0);
        check("empty_res_redirect", 32'(redirect_valid), 32'd0);
        check("error_set", 32'(error), 32'd1);
        idle();
        idle();
        check("error_sticky", 32'(error), 32'd1);

        // Asynchronous reset mid-stream
        push(2'd2, 1'b1, 8'h60, 22'h000800);
        push(2'd1, 1'b1, 8'h61, 22'h000900);
        check("pre_reset_empty", 32'(empty), 32'h9);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_empty", 32'(empty), 32'hF);
        check("async_reset_error", 32'(error), 32'd0);
        check("async_reset_upd", 32'(upd_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        push(2'd1, 1'b1, 8'h70, 22'h000A00);
        expect_upd(2'd1, 8'h70, 1'b0, 1'b1, 22'h000A00);
        resolve(2'd1, 1'b0);
        idle();
        idle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Tracks every in-flight branch prediction per hardware thread, from fetch-time prediction to ALU resolution.
- Compares the actual outcome against the stored prediction and produces the feedback packet consumed by the gshare predictor: index, taken, mispredict.
- Also produces the per-thread fetch redirect and the wrong-path flush.
- Sits between the fetch-stage predictor output and the ALU branch-compare output.

Parameters:
ADDRESS_WIDTH, 22, instruction address width; also the width of the recovery PC.
GHR_SIZE, 8, width of the gshare index stored per entry.
NUM_THREADS, 4, number of hardware threads; thread id width is 2.
DEPTH, 4, in-flight branch entries per thread; must be a power of 2.

Ports:
i_Clk  in  1  clock, rising edge.
i_Reset_n  in  1  asynchronous, active-low reset.
i_fetch_valid  in  1  predicted branch issued from fetch this cycle.
i_fetch_thread  in  2  thread of the fetched branch.
i_fetch_taken  in  1  predictor output (o_taken) for this branch.
i_fetch_index  in  GHR_SIZE  gshare index (GHR xor address) used for the prediction.
i_fetch_alt_pc  in  ADDRESS_WIDTH  PC of the path not chosen, used as the recovery PC.
o_fetch_stall  out  1  combinational; high when the queue of i_fetch_thread is full.
i_res_valid  in  1  a branch resolved in the ALU this cycle.
i_res_thread  in  2  thread of the resolved branch.
i_res_taken  in  1  actual outcome; 1 = taken.
o_upd_valid  out  1  predictor update strobe, one cycle.
o_upd_thread  out  2  thread of the update.
o_upd_index  out  GHR_SIZE  stored gshare index of the resolved branch.
o_upd_taken  out  1  actual outcome.
o_upd_mispredict  out  1  stored prediction differs from the actual outcome.
o_redirect_valid  out  1  fetch redirect strobe, one cycle.
o_redirect_thread  out  2  thread to redirect.
o_redirect_pc  out  ADDRESS_WIDTH  recovery PC.
o_empty  out  NUM_THREADS  per-thread queue empty flags.
o_error  out  1  sticky; set when a resolve arrives for an empty queue.

Behaviour:
- Reset (async, i_Reset_n=0): all pointers 0, all queues empty, o_empty all 1s. Every other output is 0, including o_error.
- Per thread: circular FIFO with read and write pointers of log2(DEPTH)+1 bits. The extra bit is the wrap bit.
  - full: pointer low bits equal and wrap bits differ.
  - empty: pointers equal.
  - Pointers wrap modulo 2*DEPTH with no special case.
- Push: i_fetch_valid and not full(i_fetch_thread). Writes {taken, index, alt_pc} at the write pointer, then increments it.
  - i_fetch_valid while full: entry is dropped, state unchanged. Upstream must hold the branch while o_fetch_stall=1.
- Resolve: i_res_valid and not empty(i_res_thread). Reads the head entry and increments the read pointer.
  - mispredict = head.taken xor i_res_taken.
- Resolve latency is 1 cycle. On the edge after a resolve:
  - o_upd_valid=1, with o_upd_thread, o_upd_index, o_upd_taken and o_upd_mispredict registered from that resolve.
  - If mispredict: o_redirect_valid=1, o_redirect_thread set, o_redirect_pc=head.alt_pc.
  - All strobes return to 0 the next cycle unless another resolve occurs.
- Mispredict flush: on the same edge as the pop, the thread's write pointer is set equal to its new read pointer. All younger entries are discarded as wrong-path.
  - A same-cycle push to the same thread is also discarded.
  - Pushes to other threads proceed normally.
- Simultaneous push and resolve, same thread, no mispredict: both occur and occupancy is unchanged. o_fetch_stall uses the pre-edge count, so a full queue still stalls.
- Resolve on an empty queue: no pop, no update, no redirect. o_error is set and holds until reset.
- o_redirect_pc and o_upd_* hold their last values when their strobes are low.

Decomposition:
- Shared package bp_pkg:
  - THREAD_W = 2.
  - Entry struct bp_entry_t {taken, index[GHR_SIZE], alt_pc[ADDRESS_WIDTH]}.
  - Update packet struct bp_update_t {thread, index, taken, mispredict}.
- Sub-module branch_inflight_fifo: one thread's FIFO, with push, pop, flush, full and empty. Instantiated NUM_THREADS times by generate.
- The top level holds the compare logic and the output registers.

Test Plan:
- Push thread 0 {taken=1, index=8'h3C, alt_pc=22'h000104}; resolve thread 0 with taken=1 next cycle -> one cycle later: o_upd_valid=1, o_upd_index=8'h3C, o_upd_mispredict=0, o_redirect_valid=0; o_empty[0]=1.
- Push thread 2 entries A{taken=0, alt_pc=22'h000200}, B, C; resolve thread 2 with taken=1 -> o_redirect_valid=1, o_redirect_thread=2, o_redirect_pc=22'h000200, o_upd_mispredict=1; B and C flushed, o_empty[2]=1.
- Push 4 entries on thread 1 -> o_fetch_stall=1 when i_fetch_thread=1; a 5th push is ignored; then 4 resolves return indices in push order, and o_empty[1]=1 after the 4th.
- Push 3 entries and resolve them repeatedly to cross the wrap, 10 entries total on thread 3 -> indices in order and no spurious full.
- Resolve thread 1 while its queue is empty -> o_upd_valid=0, o_redirect_valid=0, o_error=1 and sticky; i_Reset_n low mid-stream -> all queues empty and o_error=0 immediately, without waiting for a clock edge.
- Same cycle: push thread 0, resolve thread 0 with mispredict, push 8'h11 -> thread 0 empty afterwards, and the pushed entry is never returned.
